// File: rtl/key_schedule_seq.sv
// PRESENT-80 round-key sequencer.
// Time-shares one key_schedule update per accepted round key.
module key_schedule (
  input  logic [79:0] x,
  input  logic [4:0]  i,
  output logic [79:0] r
);

  logic [79:0] rot;
  logic [3:0]  sb;

  assign rot = {x[18:0], x[79:19]};

  // PRESENT S-box applied to the top nibble after rotation
  always_comb begin
    sb = 4'h0;
    unique case (rot[79:76])
      4'h0: sb = 4'hC;
      4'h1: sb = 4'h5;
      4'h2: sb = 4'h6;
      4'h3: sb = 4'hB;
      4'h4: sb = 4'h9;
      4'h5: sb = 4'h0;
      4'h6: sb = 4'hA;
      4'h7: sb = 4'hD;
      4'h8: sb = 4'h3;
      4'h9: sb = 4'hE;
      4'hA: sb = 4'hF;
      4'hB: sb = 4'h8;
      4'hC: sb = 4'h4;
      4'hD: sb = 4'h7;
      4'hE: sb = 4'h1;
      4'hF: sb = 4'h2;
    endcase
  end

  assign r = {sb, rot[75:20], rot[19:15] ^ i, rot[14:0]};

endmodule

module key_schedule_seq #(
  parameter int ROUNDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [79:0] key,
  output logic        start_rdy,
  input  logic        abort,
  output logic [63:0] rk,
  output logic [5:0]  rk_idx,
  output logic        rk_valid,
  input  logic        rk_rdy,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  localparam logic [5:0] LAST = 6'(ROUNDS);

  state_t      state, state_d;
  logic [79:0] k_reg, k_d, k_next;
  logic [5:0]  idx, idx_d;

  key_schedule u_ks (
    .x (k_reg),
    .i (idx[4:0]),
    .r (k_next)
  );

  // state, key and index registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k_reg <= 80'h0;
      idx   <= 6'd0;
    end else begin
      state <= state_d;
      k_reg <= k_d;
      idx   <= idx_d;
    end
  end

  // next-state: load, advance on handshake, abort wins
  always_comb begin
    state_d = state;
    k_d     = k_reg;
    idx_d   = idx;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = EMIT;
          k_d     = key;
          idx_d   = 6'd1;
        end
      end
      EMIT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (rk_rdy) begin
          if (idx == LAST) begin
            state_d = DONE;
          end else begin
            k_d   = k_next;
            idx_d = idx + 6'd1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign start_rdy = (state == IDLE);
  assign rk_valid  = (state == EMIT);
  assign done      = (state == DONE);
  assign busy      = (state == EMIT) || (state == DONE);
  assign rk        = k_reg[79:16];
  assign rk_idx    = idx;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Bench for key_schedule_seq.
// Random keys/backpressure against a PRESENT-80 model.
module tb_key_schedule_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [79:0] key = '0;
  logic        abort = 1'b0;
  logic        rk_rdy = 1'b0;
  logic        start_rdy, rk_valid, done, busy;
  logic [63:0] rk;
  logic [5:0]  rk_idx;

  logic        start1 = 1'b0;
  logic [79:0] key1 = '0;
  logic        rk_rdy1 = 1'b0;
  logic        start_rdy1, rk_valid1, done1, busy1;
  logic [63:0] rk1;
  logic [5:0]  rk_idx1;

  int checks = 0;
  int errors = 0;

  localparam logic [79:0] ONES = {80{1'b1}};

  logic [3:0]  sbox_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB,
                               4'h9, 4'h0, 4'hA, 4'hD,
                               4'h3, 4'hE, 4'hF, 4'h8,
                               4'h4, 4'h7, 4'h1, 4'h2};
  logic [63:0] exp_rk [1:32];

  always #5 clk = ~clk;

  key_schedule_seq #(.ROUNDS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key),
    .start_rdy(start_rdy), .abort(abort), .rk(rk),
    .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_rdy(rk_rdy),
    .done(done), .busy(busy)
  );

  key_schedule_seq #(.ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .key(key1),
    .start_rdy(start_rdy1), .abort(1'b0), .rk(rk1),
    .rk_idx(rk_idx1), .rk_valid(rk_valid1), .rk_rdy(rk_rdy1),
    .done(done1), .busy(busy1)
  );

  function automatic logic [79:0] ks_ref(input logic [79:0] k,
                                         input int r);
    logic [79:0] t;
    t = (k << 61) | (k >> 19);
    t[79:76] = sbox_t[t[79:76]];
    t = t ^ (80'(r) << 15);
    return t;
  endfunction

  function automatic void build(input logic [79:0] k0);
    logic [79:0] k;
    k = k0;
    for (int n = 1; n <= 32; n++) begin
      exp_rk[n] = k[79:16];
      k = ks_ref(k, n);
    end
  endfunction

  function automatic logic [79:0] rand_key();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({start_rdy, rk_valid, done, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags got %b want 1000",
               {start_rdy, rk_valid, done, busy});
    end
    checks++;
    if (rk !== 64'h0 || rk_idx !== 6'd0) begin
      errors++;
      $display("FAIL reset_rk got %h/%0d want 0/0", rk, rk_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_zero_key();
    build(80'h0);
    @(negedge clk);
    checks++;
    if (start_rdy !== 1'b1) begin
      errors++;
      $display("FAIL zk_ready got %b want 1", start_rdy);
    end
    start = 1'b1; key = 80'h0; rk_rdy = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c <= 32) begin
        checks++;
        if (rk_valid !== 1'b1 || rk_idx !== 6'(c) ||
            rk !== exp_rk[c]) begin
          errors++;
          $display("FAIL zk_k%0d got v=%b i=%0d rk=%h want %h",
                   c, rk_valid, rk_idx, rk, exp_rk[c]);
        end
      end
      if (c == 2) begin
        checks++;
        if (rk !== 64'hC000000000000000) begin
          errors++;
          $display("FAIL zk_k2_const got %h want c000000000000000",
                   rk);
        end
      end
      checks++;
      if (done !== (c == 33)) begin
        errors++;
        $display("FAIL zk_done c=%0d got %b want %b",
                 c, done, c == 33);
      end
      if (c == 33) begin
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL zk_donest got v=%b b=%b want 0/1",
                   rk_valid, busy);
        end
      end
      if (c == 34) begin
        checks++;
        if (start_rdy !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL zk_back got r=%b b=%b want 1/0",
                   start_rdy, busy);
        end
      end
    end
  endtask

  task automatic test_all_ones();
    build(ONES);
    @(negedge clk);
    start = 1'b1; key = ONES; rk_rdy = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c <= 32) begin
        checks++;
        if (rk_idx !== 6'(c) || rk !== exp_rk[c]) begin
          errors++;
          $display("FAIL ones_k%0d got %0d/%h want %h",
                   c, rk_idx, rk, exp_rk[c]);
        end
      end
      if (c == 1) begin
        checks++;
        if (rk !== 64'hFFFFFFFFFFFFFFFF) begin
          errors++;
          $display("FAIL ones_k1_const got %h", rk);
        end
      end
      if (c == 2) begin
        checks++;
        if (dut.k_reg !== 80'h2FFFFFFFFFFFFFFF7FFF) begin
          errors++;
          $display("FAIL ones_kreg got %h want 2fff..7fff",
                   dut.k_reg);
        end
      end
      checks++;
      if (done !== (c == 33)) begin
        errors++;
        $display("FAIL ones_done c=%0d got %b", c, done);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [79:0] k;
    int n, dn, cyc;
    logic stall;
    logic [63:0] prk;
    logic [5:0] pidx;
    for (int t = 0; t < 4; t++) begin
      k = (t == 0) ? 80'h0 : rand_key();
      build(k);
      @(negedge clk);
      start = 1'b1; key = k; rk_rdy = 1'b0;
      n = 1; dn = 0; cyc = 0; stall = 1'b0;
      prk = '0; pidx = '0;
      do begin
        @(negedge clk);
        start = 1'b0;
        cyc++;
        if (done === 1'b1) dn++;
        if (stall) begin
          checks++;
          if (rk !== prk || rk_idx !== pidx || rk_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall got %0d/%h want %0d/%h",
                     rk_idx, rk, pidx, prk);
          end
        end
        if (rk_valid === 1'b1) begin
          checks++;
          if (n > 32 || rk_idx !== 6'(n) || rk !== exp_rk[n]) begin
            errors++;
            $display("FAIL bp_seq got %0d/%h want %0d",
                     rk_idx, rk, n);
          end
          rk_rdy = 1'($urandom_range(0, 1));
          stall = !rk_rdy;
          prk = rk; pidx = rk_idx;
          if (rk_rdy) n++;
        end else begin
          stall = 1'b0;
        end
      end while (!(start_rdy === 1'b1 && n > 32) && cyc < 400);
      checks++;
      if (n != 33 || dn != 1 || cyc >= 400) begin
        errors++;
        $display("FAIL bp_end got n=%0d done=%0d cyc=%0d want 33/1",
                 n, dn, cyc);
      end
    end
    rk_rdy = 1'b1;
  endtask

  task automatic test_abort();
    int cyc;
    @(negedge clk);
    start = 1'b1; key = 80'h0; rk_rdy = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end while (rk_idx !== 6'd5 && cyc < 20);
    checks++;
    if (cyc >= 20) begin
      errors++;
      $display("FAIL ab_wait got idx=%0d want 5", rk_idx);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (start_rdy !== 1'b1 || rk_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ab_idle got r=%b v=%b d=%b want 1/0/0",
               start_rdy, rk_valid, done);
    end
    start = 1'b1; key = ONES;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (rk_valid !== 1'b1 || rk_idx !== 6'd1 ||
        rk !== 64'hFFFFFFFFFFFFFFFF) begin
      errors++;
      $display("FAIL ab_restart got %b/%0d/%h want 1/1/ffff..",
               rk_valid, rk_idx, rk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b1; start = 1'b1; key = 80'h0;
    checks++;
    if (start_rdy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL ab_second got r=%b d=%b", start_rdy, done);
    end
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    checks++;
    if (rk_valid !== 1'b1 || rk_idx !== 6'd1 || rk !== 64'h0) begin
      errors++;
      $display("FAIL ab_startwins got %b/%0d/%h want 1/1/0",
               rk_valid, rk_idx, rk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_start_ignored();
    build(80'h0);
    @(negedge clk);
    start = 1'b1; key = 80'h0; rk_rdy = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      start = (c >= 3 && c <= 6);
      key = rand_key() | 80'h1;
      if (c <= 32) begin
        checks++;
        if (rk_idx !== 6'(c) || rk !== exp_rk[c]) begin
          errors++;
          $display("FAIL si_k%0d got %0d/%h want %h",
                   c, rk_idx, rk, exp_rk[c]);
        end
      end
      checks++;
      if (start_rdy !== 1'b0) begin
        errors++;
        $display("FAIL si_rdy c=%0d got %b want 0", c, start_rdy);
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    @(negedge clk);
    start = 1'b1; key = rand_key(); rk_rdy = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end while (rk_idx !== 6'd10 && cyc < 20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({start_rdy, rk_valid, done, busy} !== 4'b1000 ||
        rk !== 64'h0 || rk_idx !== 6'd0 || cyc >= 20) begin
      errors++;
      $display("FAIL rst_mid got %b %h %0d want 1000 0 0",
               {start_rdy, rk_valid, done, busy}, rk, rk_idx);
    end
  endtask

  task automatic test_short();
    logic [79:0] k;
    k = rand_key();
    @(negedge clk);
    start1 = 1'b1; key1 = k; rk_rdy1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checks++;
    if (rk_valid1 !== 1'b1 || rk_idx1 !== 6'd1 ||
        rk1 !== k[79:16] || done1 !== 1'b0) begin
      errors++;
      $display("FAIL short_k1 got %b/%0d/%h want 1/1/%h",
               rk_valid1, rk_idx1, rk1, k[79:16]);
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b1 || rk_valid1 !== 1'b0 || dut1.k_reg !== k) begin
      errors++;
      $display("FAIL short_done got d=%b v=%b k=%h want 1/0/%h",
               done1, rk_valid1, dut1.k_reg, k);
    end
    @(negedge clk);
    checks++;
    if (start_rdy1 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL short_idle got r=%b d=%b want 1/0",
               start_rdy1, done1);
    end
  endtask

  initial begin
    test_reset();
    test_zero_key();
    test_all_ones();
    test_backpressure();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    test_short();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_schedule_seq.md
Name: key_schedule_seq

Overview:
Sequential controller that drives the existing combinational key_schedule round function (ports r, x, i). It iterates over an 80-bit PRESENT key and streams round keys K1..K_ROUNDS (64 bits each) to a consumer through a valid/ready handshake. A single key_schedule instance is time-shared across all rounds, one update per accepted round key. The block sits between key loading and the encryption datapath's addRoundKey stage.

Parameters:
ROUNDS, 32, number of round keys emitted per load; legal range 1..32.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  load request; sampled only when start_rdy=1
key  input  80  initial key; captured on an accepted start
start_rdy  output  1  high only in IDLE
abort  input  1  synchronous cancel of the current schedule
rk  output  64  current round key, equal to k_reg[79:16]
rk_idx  output  6  index of rk, 1..ROUNDS
rk_valid  output  1  rk/rk_idx valid
rk_rdy  input  1  consumer accepts rk when rk_valid & rk_rdy
done  output  1  one-cycle pulse after the last round key is accepted
busy  output  1  high in EMIT or DONE

Behaviour:
- State: k_reg[79:0], idx[5:0], FSM {IDLE, EMIT, DONE}.
- Reset (rst=1 at a clock edge): FSM goes to IDLE, k_reg=0, idx=0. Output values after reset: start_rdy=1, rk_valid=0, done=0, busy=0, rk=0, rk_idx=0. rst overrides abort and start. Reset mid-schedule discards all progress.
- IDLE:
  - start_rdy=1.
  - On start=1: k_reg<=key, idx<=1, FSM goes to EMIT.
  - With start=0: no state change.
- EMIT:
  - rk_valid=1, rk=k_reg[79:16], rk_idx=idx.
  - On handshake (rk_rdy=1):
    - If idx==ROUNDS: FSM goes to DONE; k_reg and idx are held.
    - Otherwise: k_reg<=key_schedule(x=k_reg, i=idx[4:0]) and idx<=idx+1.
  - On rk_rdy=0: rk, rk_idx and k_reg are held stable, with no change for any number of stall cycles.
- DONE:
  - done=1 for exactly one cycle; rk_valid=0.
  - FSM goes to IDLE next cycle.
- Round-function input i: the value passed to key_schedule is always 1..31, since idx<ROUNDS≤32 whenever an update occurs. idx never wraps.
- start outside IDLE: ignored. No queuing, no effect on k_reg.
- abort=1 in EMIT or DONE: FSM goes to IDLE next cycle; done is not pulsed; k_reg and idx are held (don't-care).
  - An abort coinciding with a handshake wins. The pending update is discarded.
  - abort in IDLE has no effect.
  - start and abort asserted together in IDLE: start is taken.
- Timing and throughput:
  - start accepted at edge t gives rk_valid=1 with rk_idx=1 in the cycle after t.
  - With rk_rdy held at 1, one key is emitted per cycle; the ROUNDS keys occupy ROUNDS consecutive cycles.
  - done is asserted in the following cycle; start_rdy returns one cycle later.
  - Total for ROUNDS=32: 34 cycles from start acceptance to start_rdy=1.
- Outputs are registered or decoded from FSM/registers only. There is no combinational path from rk_rdy or start to any output except through state.

Test Plan:
1. Zero key: rst for 2 cycles, then start with key=80'h0 and rk_rdy=1 → rk_idx=1 rk=64'h0000000000000000; rk_idx=2 rk=64'hC000000000000000. Continue to K32, compare against a software PRESENT-80 schedule. done pulses exactly once, at start+33.
2. All-ones key: key=80'hFFFFFFFFFFFFFFFFFFFF → K1=64'hFFFFFFFFFFFFFFFF; K2=64'h2FFFFFFFFFFFFFFF. Internal k_reg after the first update = 80'h2FFFFFFFFFFFFFFF7FFF.
3. Backpressure: random rk_rdy (≈50%) with key=80'h0 → identical K1..K32 sequence to scenario 1. rk and rk_idx are stable throughout every stall. No index is skipped or repeated.
4. Abort and start interaction:
   - Assert abort when rk_idx=5 and rk_rdy=1 → next cycle start_rdy=1, rk_valid=0, no done pulse.
   - A new start with key=80'hFFFF… then yields K1=64'hFFFFFFFFFFFFFFFF.
5. Start ignored while busy: pulse start with a different key during EMIT → the emitted sequence is unchanged; start_rdy=0 throughout.
6. Reset mid-run and short schedule:
   - rst at rk_idx=10 → all outputs reach reset values next cycle.
   - With ROUNDS=1: start → a single rk_idx=1, done one cycle after acceptance, and key_schedule is never applied.
